shared_matmul_serial: RTL and testbench
=======================================

// Module: shared_matmul_serial
// PURPOSE
//   Masked, lane-serial successor to the combinational per-nibble GF(2) matrix layer.
//   Applies a NIBBLE_W x NIBBLE_W bit-matrix to every nibble of every share of the state.
//   Processes LANES nibbles per cycle; the map is linear, so each share is transformed
//   independently and no fresh randomness is needed.
//   Sits between the masked S-box stage and MixColumns/AddRoundKey in the DOM round datapath.
//   Two matrices are stored at accept; a per-transaction mode bit selects forward or inverse.
// PARAMETERS
//   NUM_SHARES   2   number of DOM shares (>=1)
//   NIBBLE_W     4   nibble width; matrix is NIBBLE_W*NIBBLE_W bits
//   NUM_NIBBLES  16  nibbles per share; state width SW = NUM_NIBBLES*NIBBLE_W
//   LANES        4   nibbles processed per cycle; must divide NUM_NIBBLES
// PORTS
//   clk        in   1                 rising-edge clock
//   rst_n      in   1                 asynchronous active-low reset
//   in_valid   in   1                 input transaction valid
//   in_ready   out  1                 block can accept (IDLE)
//   in_data    in   NUM_SHARES*SW     share s at [s*SW +: SW]; nibble i at [i*NIBBLE_W +: NIBBLE_W]
//   mat_fwd    in   NIBBLE_W^2        forward matrix; row r = [r*NIBBLE_W +: NIBBLE_W]
//   mat_inv    in   NIBBLE_W^2        inverse matrix, same layout
//   mode_inv   in   1                 0 = use mat_fwd, 1 = use mat_inv (sampled at accept)
//   out_valid  out  1                 result valid, held until out_ready
//   out_ready  in   1                 downstream accepts result
//   out_data   out  NUM_SHARES*SW     transformed shares, same layout as in_data
//   busy       out  1                 high in BUSY
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, lane counter=0, in_ready=1, out_valid=0, busy=0,
//     out_data=0, internal state/matrix registers=0. Reset mid-transaction drops it silently.
//   Row-to-bit mapping: result bit r of a nibble = XOR-reduce(nibble & row r).
//     For NIBBLE_W=4, 0x8421 is the identity.
//   FSM:
//     IDLE: in_ready=1. On in_valid, latch all shares, the selected matrix (mode_inv at accept
//       picks mat_fwd/mat_inv) and clear counter. -> BUSY. Matrix changes after accept are ignored.
//     BUSY: each cycle, transform nibbles [cnt*LANES +: LANES] of every share in place, then
//       cnt++. On the cycle that processes the last group (cnt = NUM_NIBBLES/LANES-1) -> DONE.
//       in_valid is ignored and in_ready=0.
//     DONE: out_valid=1, out_data=stored state (stable). On out_ready -> IDLE. in_ready stays 0
//       in DONE (no accept-on-drain overlap).
//   Latency: accept at edge 0; out_valid rises after NUM_NIBBLES/LANES further edges
//     (4 with defaults). Throughput: one transaction per NUM_NIBBLES/LANES+2 cycles minimum.
//   Shares never mix: output share s depends only on input share s. XOR of output shares
//     equals the matrix applied to XOR of input shares.
//   out_ready while out_valid=0 has no effect. in_valid with in_ready=0 is not consumed.
//     The upstream must hold it.
//   LANES = NUM_NIBBLES is legal: BUSY lasts exactly one cycle.
// TESTING
//   Identity: mat_fwd=0x8421, mode 0, share0=0x0123456789ABCDEF, share1=0xFEDCBA9876543210
//     -> out_data equals in_data; out_valid 4 cycles after accept.
//   Parity matrix: mat_fwd=0xFFFF, share0=0x7777777733333333, share1=0
//     -> share0 out=0xFFFFFFFF00000000, share1 out=0.
//   Mode select: mat_fwd=0x8421, mat_inv=0x1248 (bit reversal), mode_inv=1, share0 nibbles all 0x1
//     -> every output nibble 0x8. Same stimulus with mode_inv=0 -> 0x1.
//   Masking invariance: random M, random x, random mask m; shares (x^m, m)
//     -> out share0 ^ out share1 == M(x) for 1000 vectors.
//   Backpressure/stall: hold out_ready=0 for 10 cycles
//     -> out_valid and out_data stable, in_ready=0. A new in_valid during DONE is not accepted.
//   Reset mid-BUSY: drop rst_n at cycle 2 of BUSY
//     -> out_valid=0, in_ready=1 immediately. The next transaction produces correct output.

Source files
------------

// File: rtl/shared_matmul_serial.sv
// Masked lane-serial GF(2) nibble matrix layer: LANES nibbles of every share per cycle, shares never mix.
// Result valid NUM_NIBBLES/LANES edges after accept; held in DONE until out_ready, no accept while busy/done.
module shared_matmul_serial #(
  parameter int NUM_SHARES  = 2,
  parameter int NIBBLE_W    = 4,
  parameter int NUM_NIBBLES = 16,
  parameter int LANES       = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [NUM_SHARES*NUM_NIBBLES*NIBBLE_W-1:0] in_data,
  input  logic [NIBBLE_W*NIBBLE_W-1:0]              mat_fwd,
  input  logic [NIBBLE_W*NIBBLE_W-1:0]              mat_inv,
  input  logic                                      mode_inv,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [NUM_SHARES*NUM_NIBBLES*NIBBLE_W-1:0] out_data,
  output logic                                      busy
);

  localparam int SW     = NUM_NIBBLES * NIBBLE_W;
  localparam int DW     = NUM_SHARES * SW;
  localparam int MW     = NIBBLE_W * NIBBLE_W;
  localparam int GROUPS = NUM_NIBBLES / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST_GRP = CW'(GROUPS - 1);

  generate
    if ((NUM_NIBBLES % LANES) != 0 || LANES < 1 || NUM_SHARES < 1) begin : g_bad_params
      $error("shared_matmul_serial: LANES must divide NUM_NIBBLES and NUM_SHARES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   data_nxt;
  logic [MW-1:0]   mat_q;

  // Result bit r is the parity of the nibble masked by row r.
  function automatic logic [NIBBLE_W-1:0] apply_mat(input logic [NIBBLE_W-1:0] nib,
                                                    input logic [MW-1:0]       mat);
    logic [NIBBLE_W-1:0] res;
    res = '0;
    for (int r = 0; r < NIBBLE_W; r++) begin
      res[r] = ^(nib & mat[r*NIBBLE_W +: NIBBLE_W]);
    end
    return res;
  endfunction

  // Only the current lane group is rewritten; everything else passes through.
  always_comb begin
    data_nxt = data_q;
    for (int s = 0; s < NUM_SHARES; s++) begin
      for (int l = 0; l < LANES; l++) begin
        data_nxt[s*SW + (int'(cnt)*LANES + l)*NIBBLE_W +: NIBBLE_W] =
          apply_mat(data_q[s*SW + (int'(cnt)*LANES + l)*NIBBLE_W +: NIBBLE_W], mat_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      mat_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            mat_q    <= mode_inv ? mat_inv : mat_fwd;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          data_q <= data_nxt;
          if (cnt == LAST_GRP) begin
            cnt       <= '0;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // in_ready stays low here so a drain and a new accept never share an edge.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_shared_matmul_serial.sv
// Randomized bench for shared_matmul_serial against a per-nibble GF(2) reference model.
module tb_shared_matmul_serial;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [15:0]  mat_fwd = '0;
  logic [15:0]  mat_inv = '0;
  logic         mode_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shared_matmul_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mat_fwd   (mat_fwd),
    .mat_inv   (mat_inv),
    .mode_inv  (mode_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // y = M*x over GF(2) for every 4-bit nibble; row r of M is bits [4r+3:4r].
  function automatic logic [63:0] ref_mat(input logic [63:0] x, input logic [15:0] m);
    logic [63:0] y;
    logic [3:0]  nib;
    logic [3:0]  row;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      nib = x[i*4 +: 4];
      for (int r = 0; r < 4; r++) begin
        row = m[r*4 +: 4];
        y[i*4 + r] = ($countones(nib & row) % 2) == 1;
      end
    end
    return y;
  endfunction

  // Accept one transaction, scramble the matrix inputs afterwards, wait for the result.
  task automatic launch(input logic [127:0] d, input logic [15:0] mf, input logic [15:0] mi,
                        input logic md);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_before_send", {127'd0, in_ready}, 128'd1);
    in_data  = d;
    mat_fwd  = mf;
    mat_inv  = mi;
    mode_inv = md;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mat_fwd  = 16'($urandom);
    mat_inv  = 16'($urandom);
    mode_inv = ~md;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_timeout", {127'd0, out_valid}, 128'd1);
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_out_valid", {127'd0, out_valid}, 128'd0);
    chk("drain_in_ready", {127'd0, in_ready}, 128'd1);
  endtask

  task automatic run_one(input string tag, input logic [127:0] d, input logic [15:0] mf,
                         input logic [15:0] mi, input logic md, input logic chk_lat);
    int lat;
    logic [15:0] m;
    m = md ? mi : mf;
    launch(d, mf, mi, md);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd1);
    wait_result(lat);
    if (chk_lat) chk({tag, "_latency"}, 128'(lat), 128'd4);
    chk({tag, "_data"}, out_data, {ref_mat(d[127:64], m), ref_mat(d[63:0], m)});
    drain();
  endtask

  initial begin
    logic [127:0] held;
    logic [63:0]  x;
    logic [63:0]  msk;
    logic [15:0]  mf;
    logic [15:0]  mi;
    logic         md;
    int           lat;

    #12;
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_out_data", out_data, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("identity", {64'hFEDCBA9876543210, 64'h0123456789ABCDEF}, 16'h8421, 16'h0000, 1'b0, 1'b1);
    chk("identity_literal", out_data, {64'hFEDCBA9876543210, 64'h0123456789ABCDEF});
    run_one("parity", {64'h0, 64'h7777777733333333}, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    chk("parity_literal", out_data, {64'h0, 64'hFFFFFFFF00000000});
    run_one("mode_inv1", {64'h0, 64'h1111111111111111}, 16'h8421, 16'h1248, 1'b1, 1'b1);
    chk("mode_inv1_literal", out_data, {64'h0, 64'h8888888888888888});
    run_one("mode_inv0", {64'h0, 64'h1111111111111111}, 16'h8421, 16'h1248, 1'b0, 1'b1);
    chk("mode_inv0_literal", out_data, {64'h0, 64'h1111111111111111});

    // Stall in DONE with a competing request on in_valid.
    launch({$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 16'($urandom), 1'b0);
    wait_result(lat);
    held = out_data;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", {127'd0, out_valid}, 128'd1);
      chk("stall_out_data", out_data, held);
      chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    drain();
    chk("stall_no_accept_data", out_data, held);
    @(posedge clk); #1;
    chk("stall_no_accept_busy", {127'd0, busy}, 128'd0);

    // Reset during the second BUSY cycle.
    launch({$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 16'($urandom), 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_mid_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_mid_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_one("after_reset", {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 16'($urandom), 1'b0, 1'b1);

    // Masked shares (x^m, m): recombined output must equal M(x).
    for (int v = 0; v < 1000; v++) begin
      x   = {$urandom, $urandom};
      msk = {$urandom, $urandom};
      mf  = 16'($urandom);
      mi  = 16'($urandom);
      md  = 1'($urandom_range(0, 1));
      launch({msk, x ^ msk}, mf, mi, md);
      wait_result(lat);
      chk("mask_recombine", {64'd0, out_data[127:64] ^ out_data[63:0]}, {64'd0, ref_mat(x, md ? mi : mf)});
      chk("mask_share1", {64'd0, out_data[127:64]}, {64'd0, ref_mat(msk, md ? mi : mf)});
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
